div_sqrt_share_arb: RTL and testbench
=====================================

DIV_SQRT_SHARE_ARB -- requirements
Module: div_sqrt_share_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 63, max cycles from start pulse to Done_SI before abort; legal range 1..255.
REQ-002 SHALL size all widths from package fpu_defs_div_sqrt_tp (C_MANT, C_EXP, C_PC); no other parameters.
REQ-003 Clk_CI  in  1  single clock; all state on rising edge.
REQ-004 Rst_RBI  in  1  reset, asynchronous, active-low.
REQ-005 Req_SI  in  [1:0]  per-requester operation request, level, held until granted.
REQ-006 Op_sqrt_SI  in  [1:0]  per requester: 1 = sqrt, 0 = div.
REQ-007 Prec_DI  in  [1:0][C_PC-1:0]  per-requester precision control.
REQ-008 Mant_a_DI, Mant_b_DI  in  [1:0][C_MANT:0]  per-requester mantissas.
REQ-009 Exp_a_DI, Exp_b_DI  in  [1:0][C_EXP:0]  per-requester exponents.
REQ-010 Gnt_SO  out  [1:0]  one-cycle pulse: operands of that requester captured this edge.
REQ-011 Valid_SO  out  [1:0]  result valid for that requester; at most one bit high.
REQ-012 Ack_SI  in  [1:0]  result consumed; effective only when the matching Valid_SO bit is high.
REQ-013 Err_SO  out  [1:0]  one-cycle pulse: that requester's operation timed out.
REQ-014 Mant_z_DO  out  [C_MANT:0];  Exp_z_DO  out  [C_EXP+1:0]  held result.
REQ-015 Div_start_SO, Sqrt_start_SO, Start_SO  out  1 each  start pulses to div/sqrt unit.
REQ-016 Precision_ctl_SO  out  [C_PC-1:0];  Mant_a_DO, Mant_b_DO  out  [C_MANT:0];  Exp_a_DO, Exp_b_DO  out  [C_EXP:0]  registered operands to unit.
REQ-017 Ready_SI, Done_SI  in  1 each;  Mant_z_DI  in  [C_MANT:0];  Exp_z_DI  in  [C_EXP+1:0]  unit status and result.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> BUSY -> HOLD -> IDLE, plus BUSY -> IDLE on timeout.
REQ-019 IDLE: if Ready_SI=1 and any Req_SI bit set, SHALL choose winner, assert Gnt_SO[winner] combinationally, capture operands, op type and owner, go ISSUE; otherwise stay.
REQ-020 Arbitration SHALL be round-robin: 1-bit pointer favours requester ptr when both request; single requester wins regardless of pointer.
REQ-021 Pointer SHALL move to ~owner when the operation leaves HOLD or times out.
REQ-022 ISSUE: SHALL pulse Start_SO=1 plus exactly one of Div_start_SO/Sqrt_start_SO for one cycle, clear watchdog to 0, go BUSY.
REQ-023 BUSY: watchdog SHALL increment each cycle; on Done_SI=1 SHALL capture Mant_z_DI/Exp_z_DI and go HOLD.
REQ-024 BUSY: when watchdog reaches TIMEOUT without Done_SI, SHALL pulse Err_SO[owner], go IDLE, no Valid.
REQ-025 Done_SI and timeout in the same cycle: Done SHALL win.
REQ-026 HOLD: Valid_SO[owner]=1 with stable Mant_z_DO/Exp_z_DO until Ack_SI[owner]=1; on that edge go IDLE.
REQ-027 Ack_SI on a non-owner bit, or outside HOLD, SHALL be ignored.
REQ-028 Done_SI outside BUSY SHALL be ignored.
REQ-029 No new grant SHALL issue while in ISSUE, BUSY or HOLD; a request withdrawn before grant SHALL leave no state.
REQ-030 Operand outputs SHALL hold captured values from grant until the next grant.
REQ-031 Latency: grant at cycle 0; start pulse at cycle 1; Done_SI at cycle N gives Valid_SO at cycle N+1.

Reset
REQ-032 Rst_RBI=0 SHALL asynchronously force IDLE, pointer=0, watchdog=0, and all outputs and registers to 0.
REQ-033 Reset mid-operation SHALL drop the operation silently: no Valid_SO, no Err_SO after release.
REQ-034 After reset release, the first grant SHALL be possible in the first cycle with Ready_SI=1.

Verification
REQ-035 Single div from requester 0 with Ready_SI=1; unit returns Done at cycle 10 -> Gnt_SO=01 at cycle 0, Div_start_SO+Start_SO at cycle 1, Valid_SO=01 from cycle 11 until Ack_SI=01.
REQ-036 Req_SI=11 continuously after reset, each op acked at once -> grants alternate 01,10,01,10; Sqrt_start_SO only for requesters with Op_sqrt_SI=1.
REQ-037 TIMEOUT=5, unit never asserts Done -> Err_SO[owner] pulses 5 cycles after the start pulse; FSM back to IDLE; pointer flipped.
REQ-038 In HOLD, Ack_SI=10 while owner=0 -> Valid_SO stays 01, no new grant; a later Ack_SI=01 -> IDLE.
REQ-039 Rst_RBI pulsed low during BUSY, then late Done_SI -> all outputs 0, Valid_SO never asserted.
REQ-040 Ready_SI=0 with Req_SI=01 -> no Gnt_SO; Ready_SI rises -> Gnt_SO=01 in that same cycle.

Source files
------------

// File: rtl/fpu_defs_div_sqrt_tp.sv
// Width constants shared by the div/sqrt unit and its arbiter.
// Double-precision mantissa/exponent with a 6-bit precision field.
package fpu_defs_div_sqrt_tp;
  localparam int C_MANT = 52;
  localparam int C_EXP  = 11;
  localparam int C_PC   = 6;
endpackage

// File: rtl/div_sqrt_share_arb_if.sv
// Link between the shared-unit arbiter and the div/sqrt unit.
// master = arbiter side, slave = unit side.
interface div_sqrt_share_arb_if;
  import fpu_defs_div_sqrt_tp::*;

  logic              Div_start_SO;
  logic              Sqrt_start_SO;
  logic              Start_SO;
  logic [C_PC-1:0]   Precision_ctl_SO;
  logic [C_MANT:0]   Mant_a_DO;
  logic [C_MANT:0]   Mant_b_DO;
  logic [C_EXP:0]    Exp_a_DO;
  logic [C_EXP:0]    Exp_b_DO;
  logic              Ready_SI;
  logic              Done_SI;
  logic [C_MANT:0]   Mant_z_DI;
  logic [C_EXP+1:0]  Exp_z_DI;

  modport master (
    output Div_start_SO, Sqrt_start_SO, Start_SO,
    output Precision_ctl_SO,
    output Mant_a_DO, Mant_b_DO,
    output Exp_a_DO, Exp_b_DO,
    input  Ready_SI, Done_SI,
    input  Mant_z_DI, Exp_z_DI
  );

  modport slave (
    input  Div_start_SO, Sqrt_start_SO, Start_SO,
    input  Precision_ctl_SO,
    input  Mant_a_DO, Mant_b_DO,
    input  Exp_a_DO, Exp_b_DO,
    output Ready_SI, Done_SI,
    output Mant_z_DI, Exp_z_DI
  );
endinterface

// File: rtl/div_sqrt_share_arb.sv
// Two-requester round-robin arbiter sharing one div/sqrt unit,
// with a watchdog that aborts operations the unit never finishes.
module div_sqrt_share_arb
  import fpu_defs_div_sqrt_tp::*;
#(
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RBI,
  input  logic [1:0]                Req_SI,
  input  logic [1:0]                Op_sqrt_SI,
  input  logic [1:0][C_PC-1:0]      Prec_DI,
  input  logic [1:0][C_MANT:0]      Mant_a_DI,
  input  logic [1:0][C_MANT:0]      Mant_b_DI,
  input  logic [1:0][C_EXP:0]       Exp_a_DI,
  input  logic [1:0][C_EXP:0]       Exp_b_DI,
  output logic [1:0]                Gnt_SO,
  output logic [1:0]                Valid_SO,
  input  logic [1:0]                Ack_SI,
  output logic [1:0]                Err_SO,
  output logic [C_MANT:0]           Mant_z_DO,
  output logic [C_EXP+1:0]          Exp_z_DO,
  div_sqrt_share_arb_if.master      unit
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             ptr_q;
  logic             owner_q;
  logic             sqrt_q;
  logic [7:0]       wd_q;
  logic [C_PC-1:0]  prec_q;
  logic [C_MANT:0]  mant_a_q, mant_b_q;
  logic [C_EXP:0]   exp_a_q, exp_b_q;
  logic [C_MANT:0]  mant_z_q;
  logic [C_EXP+1:0] exp_z_q;

  logic win;
  logic grant;
  logic done_ok;
  logic timeout;
  logic acked;

  always_comb begin
    win     = (Req_SI == 2'b11) ? ptr_q : Req_SI[1];
    grant   = (state_q == IDLE) && unit.Ready_SI
              && (|Req_SI);
    done_ok = (state_q == BUSY) && unit.Done_SI;
    // Done beats the watchdog when both land in one cycle.
    timeout = (state_q == BUSY) && !unit.Done_SI
              && (wd_q == WD_LAST);
    acked   = (state_q == HOLD) && Ack_SI[owner_q];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (grant) state_d = ISSUE;
      ISSUE: state_d = BUSY;
      BUSY: begin
        if (done_ok)      state_d = HOLD;
        else if (timeout) state_d = IDLE;
      end
      HOLD:  if (acked) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Gnt_SO   = 2'b00;
    Valid_SO = 2'b00;
    Err_SO   = 2'b00;
    if (grant)             Gnt_SO[win]       = 1'b1;
    if (state_q == HOLD)   Valid_SO[owner_q] = 1'b1;
    if (timeout)           Err_SO[owner_q]   = 1'b1;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      sqrt_q   <= 1'b0;
      wd_q     <= '0;
      prec_q   <= '0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      mant_z_q <= '0;
      exp_z_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q  <= win;
        sqrt_q   <= Op_sqrt_SI[win];
        prec_q   <= Prec_DI[win];
        mant_a_q <= Mant_a_DI[win];
        mant_b_q <= Mant_b_DI[win];
        exp_a_q  <= Exp_a_DI[win];
        exp_b_q  <= Exp_b_DI[win];
      end
      if (state_q == ISSUE)     wd_q <= '0;
      else if (state_q == BUSY) wd_q <= wd_q + 8'd1;
      if (done_ok) begin
        mant_z_q <= unit.Mant_z_DI;
        exp_z_q  <= unit.Exp_z_DI;
      end
      if (timeout || acked) ptr_q <= ~owner_q;
    end
  end

  assign unit.Start_SO         = (state_q == ISSUE);
  assign unit.Div_start_SO     = (state_q == ISSUE) && !sqrt_q;
  assign unit.Sqrt_start_SO    = (state_q == ISSUE) && sqrt_q;
  assign unit.Precision_ctl_SO = prec_q;
  assign unit.Mant_a_DO        = mant_a_q;
  assign unit.Mant_b_DO        = mant_b_q;
  assign unit.Exp_a_DO         = exp_a_q;
  assign unit.Exp_b_DO         = exp_b_q;
  assign Mant_z_DO             = mant_z_q;
  assign Exp_z_DO              = exp_z_q;

endmodule

// File: tb/tb_div_sqrt_share_arb.sv
// Bench for div_sqrt_share_arb: plays both requesters and the unit,
// checking every cycle against a transaction-timeline model.
module tb_div_sqrt_share_arb;
  import fpu_defs_div_sqrt_tp::*;

  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]           req, ops, ack;
  logic [1:0][C_PC-1:0] prec;
  logic [1:0][C_MANT:0] ma, mb;
  logic [1:0][C_EXP:0]  ea, eb;
  logic [1:0]           gnt, valid, err;
  logic [C_MANT:0]      mz;
  logic [C_EXP+1:0]     ez;

  div_sqrt_share_arb_if u_if();

  div_sqrt_share_arb #(.TIMEOUT(TO)) dut (
    .Clk_CI     (clk),
    .Rst_RBI    (rst_n),
    .Req_SI     (req),
    .Op_sqrt_SI (ops),
    .Prec_DI    (prec),
    .Mant_a_DI  (ma),
    .Mant_b_DI  (mb),
    .Exp_a_DI   (ea),
    .Exp_b_DI   (eb),
    .Gnt_SO     (gnt),
    .Valid_SO   (valid),
    .Ack_SI     (ack),
    .Err_SO     (err),
    .Mant_z_DO  (mz),
    .Exp_z_DO   (ez),
    .unit       (u_if)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: one in-flight transaction described by its grant cycle.
  bit              m_busy;
  int              m_g, m_done;
  bit              m_own, m_sqrt, m_ptr;
  logic [C_PC-1:0] m_pc;
  logic [C_MANT:0] m_ma, m_mb, m_mz;
  logic [C_EXP:0]  m_ea, m_eb;
  logic [C_EXP+1:0] m_ez;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_done = -1;
    m_own = 0; m_sqrt = 0; m_ptr = 0;
    m_pc = '0; m_ma = '0; m_mb = '0;
    m_ea = '0; m_eb = '0; m_mz = '0; m_ez = '0;
  endtask

  task automatic rand_ops();
    logic [63:0] r;
    for (int i = 0; i < 2; i++) begin
      r = {$urandom(), $urandom()}; ma[i] = r[C_MANT:0];
      r = {$urandom(), $urandom()}; mb[i] = r[C_MANT:0];
      r = {$urandom(), $urandom()};
      ea[i] = r[C_EXP:0];
      eb[i] = r[2*C_EXP+1:C_EXP+1];
      prec[i] = r[63:64-C_PC];
    end
  endtask

  task automatic settle();
    #2;
  endtask

  // Compare against the model, advance it, then cross the edge.
  task automatic step();
    logic [1:0] e_gnt, e_val, e_err, oh;
    logic [2:0] e_st;
    bit w, dn;
    int t;
    e_gnt = 0; e_val = 0; e_err = 0; e_st = 0;
    w = 0; t = 0;
    dn = u_if.Done_SI;
    oh = m_own ? 2'b10 : 2'b01;
    if (!m_busy) begin
      if (u_if.Ready_SI && |req) begin
        w = (req == 2'b11) ? m_ptr : req[1];
        e_gnt = w ? 2'b10 : 2'b01;
      end
    end else begin
      t = cyc - m_g;
      if (t == 1) e_st = {1'b1, !m_sqrt, m_sqrt};
      if (m_done < 0 && t == TO + 1 && !dn) e_err = oh;
      if (m_done >= 0) e_val = oh;
    end
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("valid", 64'(valid), 64'(e_val));
    chk("err", 64'(err), 64'(e_err));
    chk("start", 64'({u_if.Start_SO, u_if.Div_start_SO,
                     u_if.Sqrt_start_SO}), 64'(e_st));
    chk("mant_a", 64'(u_if.Mant_a_DO), 64'(m_ma));
    chk("mant_b", 64'(u_if.Mant_b_DO), 64'(m_mb));
    chk("exp_prec", 64'({u_if.Exp_a_DO, u_if.Exp_b_DO,
        u_if.Precision_ctl_SO}), 64'({m_ea, m_eb, m_pc}));
    chk("mant_z", 64'(mz), 64'(m_mz));
    chk("exp_z", 64'(ez), 64'(m_ez));
    if (!m_busy) begin
      if (e_gnt != 0) begin
        m_busy = 1; m_g = cyc; m_done = -1;
        m_own = w; m_sqrt = ops[w]; m_pc = prec[w];
        m_ma = ma[w]; m_mb = mb[w];
        m_ea = ea[w]; m_eb = eb[w];
      end
    end else if (m_done < 0 && t >= 2 && dn) begin
      m_done = cyc;
      m_mz = u_if.Mant_z_DI; m_ez = u_if.Exp_z_DI;
    end else if (e_err != 0) begin
      m_busy = 0; m_ptr = !m_own;
    end else if (m_done >= 0 && ack[m_own]) begin
      m_busy = 0; m_ptr = !m_own;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet();
    req = 0; ack = 0; ops = 0;
    u_if.Done_SI = 0;
    u_if.Ready_SI = 1;
  endtask

  task automatic rnd_cycle();
    logic [63:0] r;
    req = 2'($urandom());
    ops = 2'($urandom());
    ack = 2'($urandom());
    u_if.Ready_SI = ($urandom_range(0, 4) != 0);
    u_if.Done_SI = ($urandom_range(0, 7) == 0);
    r = {$urandom(), $urandom()};
    u_if.Mant_z_DI = r[C_MANT:0];
    u_if.Exp_z_DI = 14'($urandom());
    rand_ops();
  endtask

  initial begin
    req = 0; ops = 0; ack = 0;
    rand_ops();
    u_if.Ready_SI = 0;
    u_if.Done_SI = 0;
    u_if.Mant_z_DI = '0;
    u_if.Exp_z_DI = '0;
    model_reset();
    #2;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_mant_a", 64'(u_if.Mant_a_DO), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Ready low blocks the grant; rising Ready grants at once.
    quiet(); req = 2'b01; u_if.Ready_SI = 0;
    settle(); chk("no_rdy_gnt", 64'(gnt), 64'd0);
    step();
    u_if.Ready_SI = 1;
    settle(); chk("rdy_gnt", 64'(gnt), 64'd1);
    step();
    req = 0;
    settle();
    chk("div_start", 64'({u_if.Start_SO, u_if.Div_start_SO,
        u_if.Sqrt_start_SO}), 64'b110);
    step();
    for (int i = 2; i < 10; i++) begin settle(); step(); end
    u_if.Done_SI = 1;
    u_if.Mant_z_DI = 53'h0_ABCD_1234_5678;
    u_if.Exp_z_DI = 14'h1357;
    settle(); step();
    u_if.Done_SI = 0;
    ack = 2'b10; req = 2'b10;
    settle();
    chk("valid_c11", 64'(valid), 64'd1);
    chk("mz_c11", 64'(mz), 64'h0_ABCD_1234_5678);
    step();
    settle(); chk("foreign_ack", 64'({gnt, valid}), 64'h1);
    step();
    ack = 2'b01;
    settle(); step();
    quiet();
    settle(); chk("after_ack", 64'(valid), 64'd0);
    step();

    // Both requesting: grants alternate starting with requester 1.
    req = 2'b11; ops = 2'b10;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_gnt", 64'(gnt), (k % 2 == 0) ? 64'd2 : 64'd1);
      step();
      settle();
      chk("rr_sqrt", 64'(u_if.Sqrt_start_SO),
          (k % 2 == 0) ? 64'd1 : 64'd0);
      step();
      u_if.Done_SI = 1; settle(); step();
      u_if.Done_SI = 0; ack = 2'b11; settle(); step();
      ack = 2'b00;
    end

    // Timeout on requester 1 flips the pointer to 0.
    quiet(); req = 2'b10;
    settle(); step();
    req = 0;
    for (int i = 1; i <= TO; i++) begin settle(); step(); end
    settle(); chk("timeout_err", 64'(err), 64'd2);
    step();
    req = 2'b11;
    settle(); chk("post_to_gnt", 64'(gnt), 64'd1);
    step();

    // Reset while busy drops the operation.
    req = 0;
    for (int i = 1; i < 4; i++) begin settle(); step(); end
    #2; rst_n = 1'b0; #1;
    chk("mid_rst", 64'({gnt, valid, err, u_if.Start_SO}), 64'd0);
    chk("mid_rst_ma", 64'(u_if.Mant_a_DO), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    u_if.Done_SI = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("late_done", 64'({valid, err}), 64'd0);
      step();
    end

    for (int i = 0; i < 4000; i++) begin
      rnd_cycle(); settle(); step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
